// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing one BRAM-style regfile port among NREQ hold-until-ack requesters.
// Optional REGARB_LOCK_EN adds req_lock/lock_active and a LOCKED state for atomic read-modify-write.
module regfile_port_arbiter #(
  parameter int NREQ   = 4,
  parameter int NADDR  = 6,
  parameter int RD_LAT = 1,
  localparam int GW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0][3:0]       req_we,
  input  logic [NREQ-1:0][NADDR-1:0] req_addr,
  input  logic [NREQ-1:0][31:0]      req_wdata,
`ifdef REGARB_LOCK_EN
  input  logic [NREQ-1:0]            req_lock,
  output logic                       lock_active,
`endif
  output logic [NREQ-1:0]            ack,
  output logic [31:0]                rdata,
  output logic [GW-1:0]              grant_id,
  output logic                       busy,
  output logic                       mem_en,
  output logic [3:0]                 mem_we,
  output logic [NADDR-1:0]           mem_addr,
  output logic [31:0]                mem_wdata,
  input  logic [31:0]                mem_rdata
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

`ifdef REGARB_LOCK_EN
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_LOCKED} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
`endif

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [GW-1:0]   ptr, ptr_next;
  logic [GW-1:0]   next_id;
  logic [GW-1:0]   sel_idx, cand, load_idx;
  logic            sel_found, load, capture;
  logic [3:0]      we_q;

  // Round-robin pick: first pending requester at or above ptr, wrapping.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = GW'((int'(ptr) + i) % NREQ);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign next_id = (grant_id == GW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ptr_next   = ptr;
    load       = 1'b0;
    load_idx   = sel_idx;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        if (sel_found) begin
          load       = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_next   = CW'(RD_LAT - 1);
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == '0) begin
          capture    = 1'b1;
          state_next = S_DONE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      S_DONE: begin
`ifdef REGARB_LOCK_EN
        if (req_lock[grant_id]) begin
          state_next = S_LOCKED;
        end else begin
          ptr_next   = next_id;
          state_next = S_IDLE;
        end
`else
        ptr_next   = next_id;
        state_next = S_IDLE;
`endif
      end
`ifdef REGARB_LOCK_EN
      // Only the lock holder may be granted; the pointer stays put until it releases.
      S_LOCKED: begin
        if (req[grant_id]) begin
          load       = 1'b1;
          load_idx   = grant_id;
          state_next = S_ISSUE;
        end else if (!req_lock[grant_id]) begin
          ptr_next   = next_id;
          state_next = S_IDLE;
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ptr       <= '0;
      grant_id  <= '0;
      we_q      <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      ptr   <= ptr_next;
      if (load) begin
        grant_id  <= load_idx;
        we_q      <= req_we[load_idx];
        mem_addr  <= req_addr[load_idx];
        mem_wdata <= req_wdata[load_idx];
      end
      if (capture) rdata <= mem_rdata;
    end
  end

  assign mem_en = (state == S_ISSUE);
  assign mem_we = mem_en ? we_q : 4'h0;
  assign busy   = (state == S_ISSUE) || (state == S_WAIT) || (state == S_DONE);

  always_comb begin
    ack = '0;
    if (state == S_DONE) ack[grant_id] = 1'b1;
  end

`ifdef REGARB_LOCK_EN
  assign lock_active = (state == S_LOCKED);
`endif

endmodule
